mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the MIPS pipeline. Each request is granted by priority, sequenced through the memory with a latency counter, and completed with a one-cycle acknowledge. A `freeze` output stalls the pipeline registers while any request is outstanding.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency single-port memory between the IF
//               fetch port and the MEM load/store port. Optional round-robin
//               arbitration is enabled by defining ARB_FAIR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              freeze
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_lat_load = 4'(MEM_LAT - 1);

    state_t              state_q,     state_d;
    logic                gnt_q,       gnt_d;
    logic [3:0]          lat_cnt_q,   lat_cnt_d;
    logic                ram_en_q,    ram_en_d;
    logic                ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ack_q,    if_ack_d;
    logic                mem_ack_q,   mem_ack_d;

    logic                w_mem_req;
    logic                w_pick_mem;

`ifdef ARB_FAIR_EN
    logic                last_gnt_q,  last_gnt_d;
`endif

    assign w_mem_req = mem_rd | mem_wr;

    // On contention the port that was not served last wins; a lone requester always wins.
`ifdef ARB_FAIR_EN
    assign w_pick_mem = (w_mem_req && if_req) ? ~last_gnt_q : w_mem_req;
`else
    assign w_pick_mem = w_mem_req;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        lat_cnt_d   = lat_cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
`ifdef ARB_FAIR_EN
        last_gnt_d  = last_gnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_mem_req || if_req) begin
                    gnt_d    = w_pick_mem;
                    ram_en_d = 1'b1;
                    state_d  = S_ISSUE;
`ifdef ARB_FAIR_EN
                    last_gnt_d = w_pick_mem;
`endif
                    if (w_pick_mem) begin
                        // rd+wr together is treated as a store
                        ram_we_d    = mem_wr;
                        ram_addr_d  = mem_addr;
                        ram_wdata_d = mem_wdata;
                    end else begin
                        ram_we_d    = 1'b0;
                        ram_addr_d  = if_addr;
                    end
                end
            end
            S_ISSUE: begin
                lat_cnt_d = c_lat_load;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    if (!ram_we_q) begin
                        if (gnt_q) mem_rdata_d = ram_rdata;
                        else       if_rdata_d  = ram_rdata;
                    end
                    mem_ack_d = gnt_q;
                    if_ack_d  = ~gnt_q;
                    state_d   = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            lat_cnt_q   <= 4'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            lat_cnt_q   <= lat_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge clk) begin
        if (rst) last_gnt_q <= 1'b0;
        else     last_gnt_q <= last_gnt_d;
    end
`endif

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ack   = mem_ack_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign freeze    = (if_req & ~if_ack_q) | (w_mem_req & ~mem_ack_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a fixed-latency
//               memory model and directed vector table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        freeze;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .freeze(freeze)
    );

    always #5 clk = ~clk;

    // Memory model: data is only valid in the single cycle the arbiter should sample it.
    logic [31:0] mem_arr [logic [31:0]];
    int          rd_timer = 0;
    logic [31:0] rd_data  = '0;

    always @(posedge clk) begin
        if (ram_en) begin
            rd_timer <= L;
            rd_data  <= mem_arr.exists(ram_addr) ? mem_arr[ram_addr] : 32'h0;
            if (ram_we) mem_arr[ram_addr] = ram_wdata;
        end else if (rd_timer > 0) begin
            rd_timer <= rd_timer - 1;
        end
    end

    assign ram_rdata = (rd_timer == 1) ? rd_data : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    typedef struct packed {
        logic        is_mem;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic drop_reqs();
        if_req = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, output int lat, output int en_cnt,
                           output logic en_we, output logic [31:0] en_addr,
                           output int frz, output logic [31:0] rdata, output logic ack_mem);
        lat = -1; en_cnt = 0; en_we = 1'b0; en_addr = '0; frz = 0; rdata = '0; ack_mem = 1'b0;
        if_req    = ~v.is_mem;
        if_addr   = v.addr;
        mem_rd    = v.is_mem & v.rd;
        mem_wr    = v.is_mem & v.wr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        #1;
        if (freeze) frz++;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (ram_en) begin
                en_cnt++;
                en_we   = ram_we;
                en_addr = ram_addr;
            end
            if (freeze) frz++;
            if (if_ack || mem_ack) begin
                lat     = i;
                ack_mem = mem_ack;
                rdata   = v.is_mem ? mem_rdata : if_rdata;
                drop_reqs();
            end
        end
        drop_reqs();
        @(negedge clk);
    endtask

    vec_t        vecs [7];
    int          lat, en_cnt, frz;
    logic        en_we, ack_mem;
    logic [31:0] en_addr, rdata;
    int          bad_cnt, en_seen;
    int          mem_ack_at, if_ack_at, frz_gap;
    logic [31:0] grants [3];
    int          n_gnt;

    initial begin
        mem_arr[32'h40] = 32'h8C08_0004;
        mem_arr[32'h44] = 32'h2409_0001;
        mem_arr[32'h48] = 32'h0109_5020;

        //                 mem rd  wr  addr        wdata         we  expected rdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h40,  32'h0,         1'b0, 32'h8C08_0004};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h0,         1'b0, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h104, 32'h0,         1'b0, 32'h1234_5678};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h44,  32'h0,         1'b0, 32'h2409_0001};

        // Reset with a request present: freeze is purely combinational.
        if_req = 1'b1;
        #1;
        chk("freeze_in_reset", {31'b0, freeze}, 32'h1);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        bad_cnt = 0; en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_en) en_seen++;
            if (if_ack || mem_ack || freeze || ram_we || ram_addr != 0 || ram_wdata != 0 ||
                if_rdata != 0 || mem_rdata != 0) bad_cnt++;
        end
        chk("idle_ram_en", en_seen, 0);
        chk("idle_outputs", bad_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], lat, en_cnt, en_we, en_addr, frz, rdata, ack_mem);
            chk($sformatf("v%0d_ack_lat", i), lat, L + 2);
            chk($sformatf("v%0d_ack_port", i), {31'b0, ack_mem}, {31'b0, vecs[i].is_mem});
            chk($sformatf("v%0d_en_cnt", i), en_cnt, 1);
            chk($sformatf("v%0d_ram_addr", i), en_addr, vecs[i].addr);
            chk($sformatf("v%0d_ram_we", i), {31'b0, en_we}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_freeze_cycles", i), frz, L + 2);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        chk("if_rdata_held", if_rdata, 32'h2409_0001);

        // Contention: MEM first, IF exactly MEM_LAT+3 cycles later, freeze unbroken.
        if_req = 1'b1; if_addr = 32'h48;
        mem_rd = 1'b1; mem_addr = 32'h100;
        mem_ack_at = -1; if_ack_at = -1; frz_gap = 0;
        for (int i = 1; i <= 40 && if_ack_at < 0; i++) begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack_at = i;
                mem_rd = 1'b0;
            end
            if (if_ack) begin
                if_ack_at = i;
                if_req = 1'b0;
            end else if (!freeze) begin
                frz_gap++;
            end
        end
        drop_reqs();
        @(negedge clk);
        chk("cont_mem_ack_at", mem_ack_at, L + 2);
        chk("cont_ack_spacing", if_ack_at - mem_ack_at, L + 3);
        chk("cont_freeze_gaps", frz_gap, 0);
        chk("cont_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("cont_if_rdata", if_rdata, 32'h0109_5020);

        // Reset during WAIT of a load aborts it.
        mem_rd = 1'b1; mem_addr = 32'h104;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait", {31'b0, ram_en}, 32'h0);
        rst = 1'b1;
        mem_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_rdata", mem_rdata, 32'h0);
        bad_cnt = 0;
        for (int i = 0; i < L + 4; i++) begin
            if (mem_ack || if_ack || ram_en) bad_cnt++;
            @(negedge clk);
        end
        chk("abort_no_ack", bad_cnt, 0);
        run_txn('{1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h1234_5678},
                lat, en_cnt, en_we, en_addr, frz, rdata, ack_mem);
        chk("represent_lat", lat, L + 2);
        chk("represent_rdata", rdata, 32'h1234_5678);

        // Fairness: MEM keeps requesting while IF is held.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        mem_rd = 1'b1; mem_addr = 32'h100;
        n_gnt = 0;
        for (int i = 0; i < 3; i++) grants[i] = '0;
        for (int i = 0; i < 60 && n_gnt < 3; i++) begin
            @(negedge clk);
            if (ram_en) begin
                grants[n_gnt] = ram_addr;
                n_gnt++;
            end
            if (if_ack) if_req = 1'b0;
        end
        drop_reqs();
        chk("fair_grant0", grants[0], 32'h100);
`ifdef ARB_FAIR_EN
        chk("fair_grant1", grants[1], 32'h40);
`else
        chk("fair_grant1", grants[1], 32'h100);
`endif
        chk("fair_grant2", grants[2], 32'h100);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
